// File: rtl/pll_reset_sequencer.sv
// Synchronizes the PLL reset request and releases N downstream reset domains
// in order, with a 16-bit Avalon slave for status readback and software reset.
module pll_reset_sequencer #(
   parameter int unsigned N_DOMAINS     = 3,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned GAP_CYCLES    = 8,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 areset_n,
   input  logic                 pll_resetrequest,
   input  logic [2:0]           address,
   input  logic                 chipselect,
   input  logic                 read,
   input  logic                 write,
   input  logic [15:0]          writedata,
   output logic [15:0]          readdata,
   output logic [N_DOMAINS-1:0] rst_out_n,
   output logic                 done
);

   localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam int unsigned RC_W  = 8;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOMAINS - 1);
   localparam logic [RC_W-1:0]  RC_MAX      = '1;

   typedef enum logic [1:0] {
      ASSERT      = 2'd0,
      WAIT_STABLE = 2'd1,
      RELEASE     = 2'd2,
      RUN         = 2'd3
   } state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic [N_DOMAINS-1:0]   rst_q;
   logic                   done_q;
   logic [RC_W-1:0]        reassert_q, reassert_d;
   logic [15:0]            readdata_q, readdata_d;

   logic rr_sync;
   logic ctrl_wr;
   logic sw_req;
   logic cnt_clr;
   logic reset_src;
   logic reassert_inc;
   logic unused_wd;

   assign rr_sync      = sync_q[SYNC_STAGES-1];
   assign ctrl_wr      = write && chipselect && (address == 3'd1);
   assign sw_req       = ctrl_wr && writedata[0];
   assign cnt_clr      = ctrl_wr && writedata[1];
   assign reset_src    = rr_sync || sw_req;
   assign reassert_inc = reset_src && ((state_q == RELEASE) || (state_q == RUN));
   assign unused_wd    = ^writedata[15:2];

   // Request synchronizer; resets to "request asserted"
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_resetrequest};
      end
   end

   // Sequencing FSM: reset assertion overrides every other transition
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         done_q  <= 1'b0;
      end else if (reset_src) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ASSERT: begin
               state_q <= WAIT_STABLE;
               cnt_q   <= '0;
            end
            WAIT_STABLE: begin
               if (cnt_q == STABLE_LAST) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  rst_q   <= N_DOMAINS'(1);
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (idx_q == IDX_LAST) begin
                     state_q <= RUN;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                     // rst_q is a thermometer code, so shifting in a 1 releases the next bit
                     rst_q <= (rst_q << 1) | N_DOMAINS'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= ASSERT;
            end
         endcase
      end
   end

   // Re-assertion counter; a software clear beats a same-cycle increment
   always_comb begin
      reassert_d = reassert_q;
      if (cnt_clr) begin
         reassert_d = '0;
      end else if (reassert_inc && (reassert_q != RC_MAX)) begin
         reassert_d = reassert_q + RC_W'(1);
      end
   end

   // Registered read data, held between reads
   always_comb begin
      readdata_d = readdata_q;
      if (read && chipselect) begin
         if (address == 3'd0) begin
            readdata_d = {reassert_q, 5'b0, 2'(state_q), done_q};
         end else begin
            readdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         reassert_q <= '0;
         readdata_q <= '0;
      end else begin
         reassert_q <= reassert_d;
         readdata_q <= readdata_d;
      end
   end

   assign rst_out_n = rst_q;
   assign done      = done_q;
   assign readdata  = readdata_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected release times and read
// data are queued when stimulus is applied and checked as the DUT responds.
module tb_pll_reset_sequencer;

   localparam int N      = 3;
   localparam int SYNC   = 2;
   localparam int STABLE = 16;
   localparam int GAP    = 8;
   localparam int VW     = N + 1;
   localparam int REQ_LAT = SYNC + STABLE + 1;
   localparam int SW_LAT  = STABLE + 2;

   logic          clk = 1'b0;
   logic          areset_n;
   logic          pll_resetrequest;
   logic [2:0]    address;
   logic          chipselect;
   logic          read;
   logic          write;
   logic [15:0]   writedata;
   logic [15:0]   readdata;
   logic [N-1:0]  rst_out_n;
   logic          done;

   int total = 0;
   int bad   = 0;
   logic [15:0] rd_q[$];
   int          tim_q[$];

   pll_reset_sequencer #(
      .N_DOMAINS(N), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
      .GAP_CYCLES(GAP), .CNT_W(8)
   ) dut (
      .clk(clk), .areset_n(areset_n), .pll_resetrequest(pll_resetrequest),
      .address(address), .chipselect(chipselect), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .rst_out_n(rst_out_n), .done(done)
   );

   always #5 clk = ~clk;

   task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
      logic [15:0] e;
      @(negedge clk);
      address = a; chipselect = 1'b1; read = 1'b1;
      rd_q.push_back(exp);
      @(negedge clk);
      read = 1'b0; chipselect = 1'b0; address = 3'd0;
      e = rd_q.pop_front();
      total++;
      if (readdata !== e) begin
         bad++;
         $display("FAIL %s: readdata=%h expected %h", nm, readdata, e);
      end
   endtask

   task automatic do_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write = 1'b1; writedata = d;
      @(negedge clk);
      write = 1'b0; chipselect = 1'b0; address = 3'd0; writedata = '0;
   endtask

   task automatic check_out(input logic [VW-1:0] exp, input string nm);
      total++;
      if ({done, rst_out_n} !== exp) begin
         bad++;
         $display("FAIL %s: {done,rst_out_n}=%b expected %b", nm, {done, rst_out_n}, exp);
      end
   endtask

   task automatic wait_vec(input logic [VW-1:0] tgt, input int lim, input string nm);
      int k;
      k = 0;
      while (({done, rst_out_n} !== tgt) && (k < lim)) begin
         @(negedge clk);
         k++;
      end
      total++;
      if ({done, rst_out_n} !== tgt) begin
         bad++;
         $display("FAIL %s: out=%b expected %b within %0d cycles", nm, {done, rst_out_n}, tgt, lim);
      end
   endtask

   // Expected rise cycle of each output (and done), counted from stimulus cycle k0
   task automatic watch_release(input int first_lat, input int k0, input logic [7:0] cnt,
                                input string nm);
      int k, e, tgt;
      logic [VW-1:0] pv, v, ev;
      for (int i = 0; i <= N; i++) tim_q.push_back(first_lat + i * GAP);
      k = k0; e = 0; pv = '0;
      while ((tim_q.size() > 0) && (k < first_lat + N * GAP + 40)) begin
         @(negedge clk);
         k++;
         v = {done, rst_out_n};
         if (v !== pv) begin
            tgt = tim_q.pop_front();
            ev  = VW'((1 << (e + 1)) - 1);
            total++;
            if ((v !== ev) || (k != tgt)) begin
               bad++;
               $display("FAIL %s step%0d: out=%b at cycle %0d, expected %b at cycle %0d",
                        nm, e, v, k, ev, tgt);
            end
            pv = v;
            e++;
         end
      end
      while (tim_q.size() > 0) begin
         tgt = tim_q.pop_front();
         total++; bad++;
         $display("FAIL %s: timeout, step due at cycle %0d never seen", nm, tgt);
      end
      do_read(3'd0, {cnt, 8'h07}, {nm, "_status"});
   endtask

   task automatic do_areset();
      @(negedge clk);
      areset_n = 1'b0; pll_resetrequest = 1'b1;
      repeat (2) @(negedge clk);
      areset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      int early;
      areset_n = 1'b0; pll_resetrequest = 1'b1;
      address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
      repeat (3) @(negedge clk);
      check_out('0, "reset_outputs");
      total++;
      if (readdata !== 16'h0000) begin
         bad++;
         $display("FAIL reset_readdata: readdata=%h expected 0000", readdata);
      end
      areset_n = 1'b1;
      early = 0;
      repeat (100) begin
         @(negedge clk);
         if ({done, rst_out_n} !== '0) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL powerup_hold: %0d cycles with outputs released, expected 0", early);
      end
      do_read(3'd0, 16'h0000, "powerup_status");
   endtask

   task automatic test_clean_release();
      pll_resetrequest = 1'b0;
      watch_release(REQ_LAT, 0, 8'd0, "clean");
      do_read(3'd1, 16'h0000, "ctrl_reads_zero");
      do_read(3'd6, 16'h0000, "unmapped_reads_zero");
      do_write(3'd3, 16'h0003);
      repeat (3) @(negedge clk);
      check_out('1, "unmapped_write_ignored");
   endtask

   task automatic test_reassert_run();
      @(negedge clk);
      pll_resetrequest = 1'b1;
      @(negedge clk); check_out('1, "reassert_sync1");
      @(negedge clk); check_out('1, "reassert_sync2");
      @(negedge clk); check_out('0, "reassert_drop");
      @(negedge clk);
      pll_resetrequest = 1'b0;
      watch_release(REQ_LAT, 0, 8'd1, "reassert_reseq");
   endtask

   task automatic test_glitch();
      int rel;
      do_areset();
      @(negedge clk);
      pll_resetrequest = 1'b0;
      rel = 0;
      repeat (12) begin
         @(negedge clk);
         if ({done, rst_out_n} !== '0) rel++;
      end
      pll_resetrequest = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if ({done, rst_out_n} !== '0) rel++;
      end
      total++;
      if (rel != 0) begin
         bad++;
         $display("FAIL glitch_no_release: %0d released cycles, expected 0", rel);
      end
      pll_resetrequest = 1'b0;
      watch_release(REQ_LAT, 0, 8'd0, "glitch_reseq");
   endtask

   task automatic test_sw_reset();
      @(negedge clk);
      pll_resetrequest = 1'b1;
      repeat (4) @(negedge clk);
      pll_resetrequest = 1'b0;
      wait_vec(4'b0011, 80, "sw_reach_idx1");
      do_write(3'd1, 16'h0001);
      check_out('0, "sw_drop");
      watch_release(SW_LAT, 1, 8'd2, "sw_reseq");
      do_write(3'd1, 16'h0002);
      do_read(3'd0, 16'h0007, "sw_clear_count");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         do_write(3'd1, 16'h0001);
         wait_vec(4'b0001, 40, "sat_reach_release");
      end
      do_read(3'd0, 16'hFF04, "sat_status");
      @(negedge clk);
      areset_n = 1'b0;
      pll_resetrequest = 1'b0;
      #1;
      check_out('0, "areset_outputs");
      total++;
      if (readdata !== 16'h0000) begin
         bad++;
         $display("FAIL areset_readdata: readdata=%h expected 0000", readdata);
      end
      @(negedge clk);
      areset_n = 1'b1;
      watch_release(REQ_LAT, 0, 8'd0, "post_areset");
   endtask

   initial begin
      test_reset();
      test_clean_release();
      test_reassert_run();
      test_glitch();
      test_sw_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
